// File: rtl/mul128_stream_ctrl_if.sv
// Operand-in / product-out stream bundle for mul128_stream_ctrl.
// The master side is the producer of operands and the consumer of products.
interface mul128_stream_ctrl_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mul128_stream_ctrl.sv
// Streams two 128-bit operands in W-bit words, multiplies them with a Karatsuba
// multiplier and streams the exact 256-bit product back out, LS word first.
module karatsuba_mul_128 (
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [255:0] c
);
  logic [127:0] z0;
  logic [127:0] z2;
  logic [64:0]  a_sum;
  logic [64:0]  b_sum;
  logic [129:0] zm;
  logic [129:0] z1;

  // One level of Karatsuba: three 64/65-bit products instead of four.
  always_comb begin
    z0    = {64'b0, a[63:0]} * {64'b0, b[63:0]};
    z2    = {64'b0, a[127:64]} * {64'b0, b[127:64]};
    a_sum = {1'b0, a[63:0]} + {1'b0, a[127:64]};
    b_sum = {1'b0, b[63:0]} + {1'b0, b[127:64]};
    zm    = {65'b0, a_sum} * {65'b0, b_sum};
    z1    = zm - {2'b0, z0} - {2'b0, z2};
    c     = {z2, z0} + {62'b0, z1, 64'b0};
  end
endmodule

module mul128_stream_ctrl #(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mul128_stream_ctrl_if.slave   s,
  output logic                  busy
);
  localparam int NA = 128 / W;
  localparam int NC = 256 / W;
  localparam int CW = $clog2(NC);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, MUL, OUT} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [127:0]   a_reg;
  logic [127:0]   b_reg;
  logic [255:0]   p_reg;
  logic [255:0]   c;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [W-1:0]   out_data_r;
  logic           in_hs;
  logic [31:0]    wr_base;
  logic [31:0]    rd_base;

  karatsuba_mul_128 u_mul (
    .a (a_reg),
    .b (b_reg),
    .c (c)
  );

  assign s.in_ready  = in_ready_r;
  assign s.out_valid = out_valid_r;
  assign s.out_data  = out_data_r;
  assign in_hs       = in_ready_r & s.in_valid;
  assign wr_base     = 32'(cnt) * 32'(W);
  assign rd_base     = 32'(cnt + 1'b1) * 32'(W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_A;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      p_reg       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (in_hs) begin
          a_reg[wr_base +: W] <= s.in_data;
          busy                <= 1'b1;
          if (cnt == CW'(NA - 1)) begin
            state <= LOAD_B;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD_B: if (in_hs) begin
          b_reg[wr_base +: W] <= s.in_data;
          if (cnt == CW'(NA - 1)) begin
            state      <= MUL;
            cnt        <= '0;
            in_ready_r <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Two cycles here: the multiplier settles for a full cycle after the
        // last B word lands, and the product is captured on the second edge.
        MUL: begin
          if (cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            p_reg       <= c;
            out_data_r  <= c[W-1:0];
            out_valid_r <= 1'b1;
            cnt         <= '0;
            state       <= OUT;
          end
        end
        OUT: if (s.out_ready) begin
          if (cnt == CW'(NC - 1)) begin
            state       <= LOAD_A;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            in_ready_r  <= 1'b1;
            busy        <= 1'b0;
          end else begin
            cnt        <= cnt + 1'b1;
            out_data_r <= p_reg[rd_base +: W];
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_mul128_stream_ctrl.sv
// Directed bench for mul128_stream_ctrl at W=32 with a wide-multiply reference.
module tb_mul128_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  mul128_stream_ctrl_if #(.W(32)) bus ();

  mul128_stream_ctrl #(.W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .s    (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_wait in_ready=%b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input logic [127:0] a, input logic [127:0] b, input int maxgap);
    for (int k = 0; k < 4; k++) send_word(a[k*32 +: 32], $urandom_range(0, maxgap));
    for (int k = 0; k < 4; k++) send_word(b[k*32 +: 32], $urandom_range(0, maxgap));
  endtask

  // mode 0: always ready, 1: ready toggles each cycle, 2: random ready
  task automatic recv(input logic [255:0] p, input int mode, input string name);
    int   j;
    int   cyc;
    logic rdy;
    j   = 0;
    cyc = 0;
    while (j < 8 && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== p[j*32 +: 32]) begin
          errors++;
          $display("FAIL %s word%0d out_data=%h required %h", name, j, bus.out_data, p[j*32 +: 32]);
        end
        if (rdy) j++;
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (j != 8) begin
      errors++;
      $display("FAIL %s_timeout words=%0d required 8", name, j);
    end else if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done in_ready=%b out_valid=%b busy=%b required 1 0 0",
               name, bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++;
    if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h required 0", bus.out_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ones_latency();
    load(128'h1, 128'h1, 0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_n out_valid=%b in_ready=%b busy=%b required 0 0 1", bus.out_valid, bus.in_ready, busy);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1 out_valid=%b required 0", bus.out_valid); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_n2 out_valid=%b required 1", bus.out_valid); end
    recv(256'h1, 0, "ones");
  endtask

  task automatic test_max();
    load({128{1'b1}}, {128{1'b1}}, 0);
    recv(256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001, 0, "max");
  endtask

  task automatic test_stall();
    load(128'h2_00000001, 128'h3, 0);
    recv(256'h6_00000003, 1, "stall");
  endtask

  task automatic test_random();
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] p;
    for (int n = 0; n < 1000; n++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      p = {128'b0, a} * {128'b0, b};
      load(a, b, 2);
      recv(p, 2, "rand");
    end
  endtask

  task automatic test_abort_load();
    for (int k = 0; k < 6; k++) send_word(32'hA5A5_0000 + 32'(k), 0);
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_load_state in_ready=%b busy=%b out_valid=%b required 1 0 0",
               bus.in_ready, busy, bus.out_valid);
    end
    load(128'h5, 128'h7, 0);
    recv(256'h23, 0, "abort_load");
  endtask

  task automatic test_abort_out();
    int t;
    load({128{1'b1}}, {128{1'b1}}, 0);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      tick();
      t++;
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ((j == 0) ? 32'h1 : 32'h0)) begin
        errors++;
        $display("FAIL abort_out_word%0d out_valid=%b out_data=%h required 1 %h",
                 j, bus.out_valid, bus.out_data, (j == 0) ? 32'h1 : 32'h0);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_out_state out_valid=%b in_ready=%b busy=%b out_data=%h required 0 1 0 0",
               bus.out_valid, bus.in_ready, busy, bus.out_data);
    end
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_idle out_valid=%b required 0", bus.out_valid); end
    load(128'h9, 128'h9, 0);
    recv(256'h51, 0, "abort_out");
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ones_latency();
    test_max();
    test_stall();
    test_abort_load();
    test_abort_out();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
